dot_accum_int16: RTL and testbench

DOT_ACCUM_INT16 -- requirements
Module: dot_accum_int16

---
 rtl/dot_accum_int16.sv | 83 ++++++++
 tb/tb_dot_accum_int16.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/dot_accum_int16.sv
// Streaming dot-product accumulator: sums signed product terms until in_last,
// then holds the wrapped sum and saturating term count until the consumer takes it.
module dot_accum_int16 #(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 32,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0] out_count
);

    typedef enum logic {ACCUM = 1'b0, OUT = 1'b1} state_t;

    state_t                       state, state_nxt;
    logic signed [ACC_WIDTH-1:0]  acc;
    logic signed [ACC_WIDTH-1:0]  acc_sum;
    logic signed [WIDTH-1:0]      term_s;
    logic        [CNT_WIDTH-1:0]  cnt;
    logic        [CNT_WIDTH-1:0]  cnt_inc;
    logic                         accept;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
        if (&c) return c;
        return c + CNT_WIDTH'(1);
    endfunction

    // Signed size cast sign-extends the term; the add wraps modulo 2^ACC_WIDTH.
    always_comb begin
        term_s  = in_data;
        acc_sum = acc + ACC_WIDTH'(term_s);
        cnt_inc = sat_inc(cnt);
    end

    always_comb begin
        state_nxt = state;
        in_ready  = (state == ACCUM);
        out_valid = (state == OUT);
        accept    = 1'b0;
        case (state)
            ACCUM: begin
                accept = in_valid;
                if (in_valid && in_last) state_nxt = OUT;
            end
            OUT: begin
                if (out_ready) state_nxt = ACCUM;
            end
            default: state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ACCUM;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            out_data  <= '0;
            out_count <= '0;
        end else if (accept) begin
            acc <= acc_sum;
            cnt <= cnt_inc;
            if (in_last) begin
                out_data  <= acc_sum;
                out_count <= cnt_inc;
            end
        end else if (state == OUT && out_ready) begin
            acc <= '0;
            cnt <= '0;
        end
    end

endmodule

// File: tb/tb_dot_accum_int16.sv
// Bench for dot_accum_int16: three configurations (default, 16-bit accumulator,
// 2-bit counter) driven in lockstep and compared against a plain-arithmetic model.
module tb_dot_accum_int16;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_last, out_ready;
    logic [15:0] in_data;

    logic        in_ready0, in_ready1, in_ready2;
    logic        out_valid0, out_valid1, out_valid2;
    logic [31:0] out_data0, out_data2;
    logic [15:0] out_data1;
    logic [7:0]  out_count0, out_count1;
    logic [1:0]  out_count2;

    int n_assert = 0;
    int n_fail   = 0;
    logic [15:0] terms[$];

    always #5 clk = ~clk;

    dot_accum_int16 u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid0),
        .out_ready(out_ready), .out_data(out_data0), .out_count(out_count0));

    dot_accum_int16 #(.WIDTH(16), .ACC_WIDTH(16), .CNT_WIDTH(8)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid1),
        .out_ready(out_ready), .out_data(out_data1), .out_count(out_count1));

    dot_accum_int16 #(.WIDTH(16), .ACC_WIDTH(32), .CNT_WIDTH(2)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid2),
        .out_ready(out_ready), .out_data(out_data2), .out_count(out_count2));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ready0"}, {31'b0, in_ready0}, 32'd1);
        check({tag, "_ready1"}, {31'b0, in_ready1}, 32'd1);
        check({tag, "_ready2"}, {31'b0, in_ready2}, 32'd1);
        check({tag, "_valid0"}, {31'b0, out_valid0}, 32'd0);
        check({tag, "_valid1"}, {31'b0, out_valid1}, 32'd0);
        check({tag, "_valid2"}, {31'b0, out_valid2}, 32'd0);
    endtask

    task automatic check_result(input string tag, input logic [31:0] e32,
                                input logic [15:0] e16, input logic [7:0] c8,
                                input logic [1:0] c2);
        check({tag, "_valid0"}, {31'b0, out_valid0}, 32'd1);
        check({tag, "_valid1"}, {31'b0, out_valid1}, 32'd1);
        check({tag, "_valid2"}, {31'b0, out_valid2}, 32'd1);
        check({tag, "_ready0"}, {31'b0, in_ready0}, 32'd0);
        check({tag, "_ready2"}, {31'b0, in_ready2}, 32'd0);
        check({tag, "_data0"}, out_data0, e32);
        check({tag, "_data1"}, {16'b0, out_data1}, {16'b0, e16});
        check({tag, "_data2"}, out_data2, e32);
        check({tag, "_count0"}, {24'b0, out_count0}, {24'b0, c8});
        check({tag, "_count1"}, {24'b0, out_count1}, {24'b0, c8});
        check({tag, "_count2"}, {30'b0, out_count2}, {30'b0, c2});
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [15:0] d, input logic last);
        int guard = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("send_ready_wait", {31'b0, in_ready0}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'($urandom);
        in_data  = 16'($urandom);
    endtask

    task automatic run_vector(input string tag, input int hold, input int max_gap);
        longint s = 0;
        int n;
        logic [31:0] e32;
        logic [15:0] e16;
        logic [7:0]  c8;
        logic [1:0]  c2;
        foreach (terms[i]) s += longint'($signed(terms[i]));
        n   = terms.size();
        e32 = s[31:0];
        e16 = s[15:0];
        c8  = (n > 255) ? 8'd255 : 8'(n);
        c2  = (n > 3) ? 2'd3 : 2'(n);

        out_ready = (hold == 0);
        foreach (terms[i]) begin
            repeat ($urandom_range(max_gap, 0)) begin
                in_valid = 1'b0;
                in_data  = 16'($urandom);
                in_last  = 1'($urandom);
                @(negedge clk);
            end
            send(terms[i], (i == n - 1));
        end
        check_result({tag, "_res"}, e32, e16, c8, c2);

        // Pending result must hold still and refuse terms
        for (int k = 0; k < hold; k++) begin
            in_valid  = 1'b1;
            in_data   = 16'($urandom);
            in_last   = 1'($urandom);
            out_ready = 1'b0;
            @(negedge clk);
            check_result({tag, "_hold"}, e32, e16, c8, c2);
        end
        out_ready = 1'b1;
        in_valid  = 1'($urandom);
        in_data   = 16'($urandom);
        @(negedge clk);
        in_valid  = 1'b0;
        check_idle({tag, "_after"});
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_idle("reset");
        check("reset_data0", out_data0, 32'd0);
        check("reset_count0", {24'b0, out_count0}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        terms = '{16'd3, 16'd5, 16'd7};
        run_vector("basic", 0, 0);
        terms = '{16'hFFFF, 16'h0002};
        run_vector("neg", 1, 1);
        terms = '{16'h7FFF, 16'h0001};
        run_vector("wrap", 2, 0);
        terms = '{16'd1, 16'd1, 16'd1, 16'd1, 16'd1};
        run_vector("cntsat", 5, 2);
        terms = '{16'h8000};
        run_vector("single", 0, 1);

        // Reset mid-vector discards the partial sum
        send(16'd100, 1'b0);
        send(16'd200, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle("midrst");
        check("midrst_data0", out_data0, 32'd0);
        check("midrst_count0", {24'b0, out_count0}, 32'd0);
        terms = '{16'd4, 16'd6};
        run_vector("postrst", 0, 0);

        terms.delete();
        for (int i = 0; i < 300; i++) terms.push_back(16'($urandom));
        run_vector("long", 1, 0);

        for (int v = 0; v < 15; v++) begin
            terms.delete();
            for (int i = 0; i < int'($urandom_range(10, 1)); i++)
                terms.push_back(16'($urandom));
            run_vector("rand", int'($urandom_range(3, 0)), 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
